// File: rtl/glb_weight_loader.sv
// Streams per-PE filter rows from the weight GLB into the PE weight scratchpads.
// A 2-entry skid FIFO absorbs the GLB's registered read latency under backpressure.
module glb_weight_loader #(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH      = 10,
    parameter int NUM_PE             = 3,
    parameter int PE_BITWIDTH        = $clog2(NUM_PE) + 1,
    parameter int SPAD_ADDR_BITWIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_BITWIDTH-1:0]      cfg_base_addr,
    input  logic [SPAD_ADDR_BITWIDTH:0]   cfg_filt_len,
    input  logic [PE_BITWIDTH-1:0]        cfg_num_pe,
    output logic                          glb_read_req,
    output logic [ADDR_BITWIDTH-1:0]      glb_r_addr,
    input  logic [DATA_BITWIDTH-1:0]      glb_r_data,
    output logic                          w_valid,
    input  logic                          w_ready,
    output logic [DATA_BITWIDTH-1:0]      w_data,
    output logic [PE_BITWIDTH-1:0]        w_pe_sel,
    output logic [SPAD_ADDR_BITWIDTH-1:0] w_spad_addr,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    dbg_state_o
);
    localparam int LEN_W = SPAD_ADDR_BITWIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [LEN_W-1:0]              filt_len_q;
    logic [PE_BITWIDTH-1:0]        num_pe_q;
    logic [ADDR_BITWIDTH-1:0]      rd_addr_q;
    logic [PE_BITWIDTH-1:0]        rd_pe_q;
    logic [SPAD_ADDR_BITWIDTH-1:0] rd_idx_q;
    logic                          inflight_q;
    logic [PE_BITWIDTH-1:0]        tag_pe_q;
    logic [SPAD_ADDR_BITWIDTH-1:0] tag_idx_q;

    logic [DATA_BITWIDTH-1:0]      fifo_data_q [2];
    logic [PE_BITWIDTH-1:0]        fifo_pe_q   [2];
    logic [SPAD_ADDR_BITWIDTH-1:0] fifo_idx_q  [2];
    logic                          wr_ptr_q, rd_ptr_q;
    logic [1:0]                    fifo_cnt_q;

    logic pop, issue, room, last_idx, last_pe, head_last, degenerate;

    assign w_valid     = (fifo_cnt_q != 2'd0);
    assign w_data      = fifo_data_q[rd_ptr_q];
    assign w_pe_sel    = fifo_pe_q[rd_ptr_q];
    assign w_spad_addr = fifo_idx_q[rd_ptr_q];
    assign pop         = w_valid && w_ready;

    // A read may only go out when its word is guaranteed a FIFO slot on return.
    assign room       = (fifo_cnt_q + {1'b0, inflight_q}) < 2'd2;
    assign issue      = (state_q == S_ISSUE) && (room || pop);
    assign last_idx   = ({1'b0, rd_idx_q} == filt_len_q - LEN_W'(1));
    assign last_pe    = (rd_pe_q == num_pe_q - PE_BITWIDTH'(1));
    assign head_last  = (w_pe_sel == num_pe_q - PE_BITWIDTH'(1)) &&
                        ({1'b0, w_spad_addr} == filt_len_q - LEN_W'(1));
    assign degenerate = (cfg_filt_len == '0) || (cfg_num_pe == '0);

    always_comb begin
        state_d      = state_q;
        glb_read_req = issue;
        glb_r_addr   = rd_addr_q;
        busy         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done         = (state_q == S_DONE);
        dbg_state_o  = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = degenerate ? S_DONE : S_ISSUE;
            S_ISSUE: if (issue && last_idx && last_pe) state_d = S_DRAIN;
            S_DRAIN: if (pop && head_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            filt_len_q <= '0;
            num_pe_q   <= '0;
            rd_addr_q  <= '0;
            rd_pe_q    <= '0;
            rd_idx_q   <= '0;
            inflight_q <= 1'b0;
            tag_pe_q   <= '0;
            tag_idx_q  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pe_q[i]   <= '0;
                fifo_idx_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                filt_len_q <= cfg_filt_len;
                num_pe_q   <= cfg_num_pe;
                rd_addr_q  <= cfg_base_addr;
                rd_pe_q    <= '0;
                rd_idx_q   <= '0;
            end else if (issue) begin
                rd_addr_q <= rd_addr_q + ADDR_BITWIDTH'(1);
                if (last_idx) begin
                    rd_idx_q <= '0;
                    rd_pe_q  <= rd_pe_q + PE_BITWIDTH'(1);
                end else begin
                    rd_idx_q <= rd_idx_q + SPAD_ADDR_BITWIDTH'(1);
                end
            end
            inflight_q <= issue;
            if (issue) begin
                tag_pe_q  <= rd_pe_q;
                tag_idx_q <= rd_idx_q;
            end
            // GLB data is valid exactly one cycle after the request.
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= glb_r_data;
                fifo_pe_q[wr_ptr_q]   <= tag_pe_q;
                fifo_idx_q[wr_ptr_q]  <= tag_idx_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({inflight_q, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_glb_weight_loader.sv
// Self-checking bench for glb_weight_loader: GLB memory model, ready pattern
// driver, and a scoreboard of expected GLB addresses and spad words.
module tb_glb_weight_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  cfg_base_addr;
    logic [4:0]  cfg_filt_len;
    logic [2:0]  cfg_num_pe;
    logic        glb_read_req;
    logic [9:0]  glb_r_addr;
    logic [15:0] glb_r_data;
    logic        w_valid;
    logic        w_ready;
    logic [15:0] w_data;
    logic [2:0]  w_pe_sel;
    logic [3:0]  w_spad_addr;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state_o;

    glb_weight_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_filt_len(cfg_filt_len), .cfg_num_pe(cfg_num_pe),
        .glb_read_req(glb_read_req), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_pe_sel(w_pe_sel), .w_spad_addr(w_spad_addr),
        .busy(busy), .done(done), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [1024];
    always @(posedge clk) if (glb_read_req) glb_r_data <= mem[glb_r_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // w_ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
    int ready_mode = 0;
    int pat = 0;
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       w_ready = ((pat % 3) == 0);
                2:       w_ready = 1'($urandom_range(0, 1));
                default: w_ready = 1'b1;
            endcase
            pat++;
        end
    end

    logic [22:0] exp_q[$];
    logic [9:0]  addr_q[$];
    bit          mon_en = 1'b0;
    int          tb_occ = 0;
    int          acc_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [22:0] prev_word = '0;

    always @(negedge clk) begin : monitor
        logic        pop_s;
        logic [22:0] cur;
        if (mon_en) begin
            pop_s = w_valid && w_ready;
            cur   = {w_pe_sel, w_spad_addr, w_data};
            if (tb_occ >= 2 && !pop_s) check("overissue", glb_read_req, 0);
            if (addr_q.size() == 0) check("no_read", glb_read_req, 0);
            else if (glb_read_req) check("glb_addr", glb_r_addr, addr_q.pop_front());
            if (prev_stall) begin
                check("stall_valid", w_valid, 1);
                check("stall_word", cur, prev_word);
            end
            if (exp_q.size() == 0) check("no_valid", w_valid, 0);
            else if (pop_s) begin
                check("w_word", cur, exp_q.pop_front());
                acc_cnt++;
            end
            tb_occ     = tb_occ + int'(glb_read_req) - int'(pop_s);
            prev_stall = w_valid && !w_ready;
            prev_word  = cur;
        end
    end

    int lat;
    int first_v;

    task automatic launch(input logic [9:0] base, input logic [4:0] flen, input logic [2:0] npe);
        logic [9:0] a;
        for (int p = 0; p < int'(npe); p++)
            for (int i = 0; i < int'(flen); i++) begin
                a = base + 10'(p * int'(flen) + i);
                exp_q.push_back({3'(p), 4'(i), mem[a]});
                addr_q.push_back(a);
            end
        acc_cnt = 0;
        @(posedge clk);
        #1;
        cfg_base_addr = base;
        cfg_filt_len  = flen;
        cfg_num_pe    = npe;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, (flen != 0 && npe != 0));
    endtask

    // lat counts clock edges after the edge that accepted start.
    task automatic wait_done(input int exp_lat, input bit poke, input int nwords);
        lat = 0;
        first_v = -1;
        while (!done && lat < 400) begin
            if (w_valid && first_v < 0) first_v = lat;
            if (poke && lat == 5) begin
                cfg_base_addr = 10'($urandom);
                cfg_filt_len  = 5'd2;
                cfg_num_pe    = 3'd1;
                start         = 1'b1;
            end
            if (poke && lat == 6) start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (exp_lat >= 0) check("done_lat", lat, exp_lat);
        @(posedge clk);
        #1;
        check("done_width", done, 0);
        check("idle_busy", busy, 0);
        check("idle_state", dbg_state_o, 0);
        check("words", acc_cnt, nwords);
        check("exp_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {glb_read_req, glb_r_addr, w_valid, w_data, w_pe_sel, w_spad_addr, busy, done}, 0);
        check("reset_state", dbg_state_o, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        reset = 1'b1;
        start = 1'b0;
        cfg_base_addr = '0;
        cfg_filt_len  = '0;
        cfg_num_pe    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_outputs");
        reset  = 1'b0;
        mon_en = 1'b1;

        // Basic load: 6 words, first word two edges after start, done after 8.
        ready_mode = 0;
        launch(10'h010, 5'd3, 3'd2);
        wait_done(8, 1'b0, 6);
        check("first_valid_lat", first_v, 2);

        ready_mode = 1;
        launch(10'h010, 5'd3, 3'd2);
        wait_done(-1, 1'b0, 6);

        ready_mode = 0;
        launch(10'h3FE, 5'd4, 3'd1);
        wait_done(6, 1'b0, 4);

        // Degenerate configs: DONE is the very next state, no reads, no words.
        launch(10'h020, 5'd0, 3'd2);
        wait_done(0, 1'b0, 0);
        launch(10'h020, 5'd3, 3'd0);
        wait_done(0, 1'b0, 0);

        // Reset once two of six words have been accepted.
        launch(10'h040, 5'd3, 3'd2);
        lat = 0;
        while (acc_cnt < 2 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("mid_accepted", acc_cnt, 2);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset_outputs");
        reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        tb_occ     = 0;
        prev_stall = 1'b0;
        mon_en     = 1'b1;
        launch(10'h040, 5'd3, 3'd2);
        wait_done(8, 1'b0, 6);

        // Full-size load with random backpressure and config/start pokes while busy.
        ready_mode = 2;
        launch(10'h100, 5'd16, 3'd3);
        wait_done(-1, 1'b1, 48);

        ready_mode = 1;
        launch(10'h3F0, 5'd16, 3'd3);
        wait_done(-1, 1'b0, 48);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/glb_weight_loader.md
Name: glb_weight_loader

Overview:
- Sequencer that streams filter weights out of the weight global buffer into the per-PE weight scratchpads before a convolution pass.
- On start, reads cfg_num_pe consecutive filter rows of cfg_filt_len words each from the GLB read port, then delivers them to PE p, spad address 0..filt_len-1, over a valid/ready channel.
- Absorbs the GLB's 1-cycle registered read latency with a 2-entry skid FIFO, so downstream backpressure never loses data.

Parameters:
- DATA_BITWIDTH, 16, weight word width.
- ADDR_BITWIDTH, 10, GLB address width.
- NUM_PE, 3, number of PE weight spads served; PE_BITWIDTH = $clog2(NUM_PE)+1.
- SPAD_ADDR_BITWIDTH, 4, spad address width; max filter length = 2^SPAD_ADDR_BITWIDTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a load; sampled only in IDLE.
- cfg_base_addr  in  ADDR_BITWIDTH  GLB address of word 0 of PE 0.
- cfg_filt_len  in  SPAD_ADDR_BITWIDTH+1  words per PE (0..2^SPAD_ADDR_BITWIDTH).
- cfg_num_pe  in  PE_BITWIDTH  PEs to load (0..NUM_PE).
- glb_read_req  out  1  GLB read strobe.
- glb_r_addr  out  ADDR_BITWIDTH  GLB read address.
- glb_r_data  in  DATA_BITWIDTH  GLB read data; valid only the cycle after glb_read_req.
- w_valid  out  1  spad write word available.
- w_ready  in  1  consumer accepts the word this cycle.
- w_data  out  DATA_BITWIDTH  weight word.
- w_pe_sel  out  PE_BITWIDTH  destination PE index.
- w_spad_addr  out  SPAD_ADDR_BITWIDTH  destination spad address.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last word is accepted.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE; FIFO, in-flight flag and counters clear. Reset mid-load aborts immediately and drops buffered words; no done pulse.
- Config latch: cfg_* are latched on the cycle start is accepted in IDLE. Later cfg changes have no effect until the next load.
- Degenerate config: start with cfg_filt_len==0 or cfg_num_pe==0 goes IDLE->DONE. No GLB reads; done pulses the next cycle.
- FSM states:
  - IDLE: busy=0. start with a non-degenerate config -> ISSUE.
  - ISSUE: issues reads. After the last read is issued -> DRAIN.
  - DRAIN: no new reads. When the last word is accepted (w_valid && w_ready) -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE. start is ignored in DONE.
- Issue counters: rd_pe (0..num_pe-1) and rd_idx (0..filt_len-1).
  - Issue address = cfg_base_addr + rd_pe*filt_len + rd_idx, computed as a running pointer incremented by 1 per issue, wrapping modulo 2^ADDR_BITWIDTH.
  - rd_idx wraps to 0 and rd_pe increments after filt_len-1.
- Issue rule: glb_read_req=1 in ISSUE iff (fifo_count + inflight < 2) or pop occurs this cycle. pop = w_valid && w_ready. glb_r_addr holds the issued address that cycle; glb_read_req=0 in all other states.
- Capture: inflight is set on issue. The next cycle glb_r_data is pushed into the FIFO together with its tag {pe, idx}, taken from the issue counters delayed one cycle.
- Output: w_valid = FIFO non-empty. w_data, w_pe_sel and w_spad_addr come from the FIFO head and stay stable while w_valid && !w_ready.
- Throughput: with w_ready held high, one word per cycle. First w_valid appears 2 cycles after start; done pulses 1 cycle after the final acceptance. Total = num_pe*filt_len + 2 cycles from start to done.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- The FIFO never overflows, and reads are never issued without guaranteed buffer space.

Test Plan:
- Basic load: base=0x010, filt_len=3, num_pe=2, w_ready=1. Required: GLB addrs 0x010..0x015 on consecutive cycles. Outputs in order (pe,addr) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with data = mem contents. done pulses exactly 8 cycles after start.
- Backpressure: same config, w_ready toggled 1,0,0,1,... Required: no word lost or duplicated; outputs stable while stalled; glb_read_req never asserted while fifo_count+inflight==2 without a pop.
- Address wrap: base=0x3FE, filt_len=4, num_pe=1. Required: reads 0x3FE, 0x3FF, 0x000, 0x001; spad addrs 0..3.
- Degenerate config: filt_len=0. Required: no glb_read_req; done one cycle after start; no w_valid. Repeat with num_pe=0 and expect the same response.
- Reset mid-load: assert reset when 2 of 6 words have been accepted. Required: next cycle all outputs 0, state IDLE. A fresh start then completes all 6 words normally.
- Config/start hygiene: change cfg_* and pulse start during busy. Required: no effect on the current load. Full-size load (filt_len=16, num_pe=3) delivers 48 words, with spad addr 15 reached per PE.
